// File: rtl/mini_uart_pkg.sv
// Shared constants and types for the UART FIFO bridge: flow-control characters,
// transmit FSM states and a width helper usable in parameter expressions.
package mini_uart_pkg;
   localparam logic [7:0] XON  = 8'h11;
   localparam logic [7:0] XOFF = 8'h13;

   typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_HI, WAIT_LO} tx_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; full/empty come from the occupancy counter and a
// push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
   import mini_uart_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full,
   output logic [AW:0]      count
);
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic                        do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // pointers are exactly AW bits wide, so the increment wraps modulo DEPTH
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end
endmodule

// File: rtl/uart_fifo_bridge.sv
// Buffered byte bridge between uartrx/uarttx and the CPU: RX and TX FIFOs, a
// transmit drain FSM with busy timeout, sticky overrun and optional XON/XOFF.
module uart_fifo_bridge
   import mini_uart_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int DEPTH    = 8,
   parameter  int FLOW     = 0,
   parameter  int HI_WM    = DEPTH - 2,
   parameter  int LO_WM    = DEPTH / 4,
   parameter  int BUSY_TMO = 4,
   localparam int CW       = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_strobe,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_start,
   input  logic             tx_busy,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             wr_en,
   output logic             wr_full,
   output logic [CW-1:0]    rx_count,
   output logic             overrun,
   input  logic             clr_overrun
);
   localparam int TW = (clog2(BUSY_TMO + 1) < 1) ? 1 : clog2(BUSY_TMO + 1);

   logic             rx_empty, rx_full;
   logic             tx_empty, tx_full, tx_push, tx_pop;
   logic [WIDTH-1:0] tx_head;
   logic [CW-1:0]    tx_count;

   tx_state_e        state;
   logic             sel_flow, sel_xoff, xoff_sent;
   logic [TW-1:0]    tmo;
   logic             need_xoff, need_xon;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
      .clk(clk), .rst_n(rst_n), .push(rx_strobe), .pop(rd_en), .din(rx_data),
      .dout(rd_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
   );

   // CPU writes into a full TX FIFO are dropped even if the FSM pops that cycle
   assign tx_push = wr_en & ~tx_full;
   assign tx_pop  = (state == LOAD) & ~sel_flow;

   sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
      .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(wr_data),
      .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
   );

   assign rd_valid = ~rx_empty;
   assign wr_full  = (tx_count == CW'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) overrun <= 1'b0;
      else if (clr_overrun) overrun <= 1'b0;
      else if (rx_strobe && rx_full && !rd_en) overrun <= 1'b1;
   end

   // level-based requests: a re-crossing before LOAD simply withdraws the request
   assign need_xoff = (FLOW != 0) && (rx_count >= CW'(HI_WM)) && !xoff_sent;
   assign need_xon  = (FLOW != 0) && (rx_count <= CW'(LO_WM)) &&  xoff_sent;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_start  <= 1'b0;
         tx_data   <= '0;
         xoff_sent <= 1'b0;
         sel_flow  <= 1'b0;
         sel_xoff  <= 1'b0;
         tmo       <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE:
               if (need_xoff || need_xon) begin
                  sel_flow <= 1'b1;
                  sel_xoff <= need_xoff;
                  state    <= LOAD;
               end else if (!tx_empty) begin
                  sel_flow <= 1'b0;
                  state    <= LOAD;
               end
            LOAD: begin
               if (sel_flow) begin
                  tx_data   <= sel_xoff ? WIDTH'(XOFF) : WIDTH'(XON);
                  xoff_sent <= sel_xoff;
               end else begin
                  tx_data <= tx_head;
               end
               tx_start <= 1'b1;
               state    <= START;
            end
            START: begin
               tmo   <= '0;
               state <= WAIT_HI;
            end
            WAIT_HI:
               if (tx_busy) state <= WAIT_LO;
               else if (tmo == TW'(BUSY_TMO - 1)) state <= IDLE;
               else tmo <= tmo + 1'b1;
            WAIT_LO:
               if (!tx_busy) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Scoreboard bench: stimulus pushes expected RX/TX bytes into queues, a negedge
// monitor pops and compares whenever the bridge delivers a byte.
module tb_uart_fifo_bridge;
   localparam int D = 8, HI = 6, LO = 2, TMO = 4;

   logic       clk = 1'b0, rst_n = 1'b1;
   logic [7:0] rx_data = '0, wr_data = '0;
   logic       rx_strobe = 1'b0, rd_en = 1'b0, wr_en = 1'b0, clr_overrun = 1'b0;
   logic       tx_busy = 1'b0;
   logic [7:0] tx_data, rd_data;
   logic       tx_start, rd_valid, wr_full, overrun;
   logic [3:0] rx_count;

   always #5 clk = ~clk;

   uart_fifo_bridge #(.WIDTH(8), .DEPTH(D), .FLOW(1), .HI_WM(HI), .LO_WM(LO),
                      .BUSY_TMO(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_en(rd_en),
      .wr_data(wr_data), .wr_en(wr_en), .wr_full(wr_full),
      .rx_count(rx_count), .overrun(overrun), .clr_overrun(clr_overrun)
   );

   int         nvec = 0, nerr = 0;
   logic [7:0] rxq[$], txq[$];
   int         rx_n = 0, cur_n = 0;
   bit         ovr_now = 0, ovr_next = 0, xoff_exp = 0;
   int         starts = 0, cyc = 0, last_start = -1;
   bit         tmo_chk = 0, busy_en = 0;
   int         busy_len = 10, bcnt = 0;

   task automatic chk(input string nm, input int act, input int want);
      nvec++;
      if (act !== want) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, want);
      end
   endtask

   // uarttx stand-in: busy rises the cycle after tx_start and stays for busy_len cycles
   always @(posedge clk) begin
      #2;
      if (!rst_n) bcnt = 0;
      else if (tx_start) bcnt = busy_len + 1;
      else if (bcnt > 0) bcnt--;
      tx_busy = busy_en && bcnt > 0 && bcnt <= busy_len;
   end

   always @(negedge clk) begin
      cyc++;
      if (rst_n) begin
         chk("rx_count", int'(rx_count), cur_n);
         chk("rd_valid", int'(rd_valid), int'(cur_n != 0));
         chk("overrun", int'(overrun), int'(ovr_now));
         if (rd_en && cur_n > 0) chk("rd_data", int'(rd_data), int'(rxq.pop_front()));
         if (tx_start) begin
            starts++;
            chk("tx_busy_at_start", int'(tx_busy), 0);
            if (txq.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL tx_start_unexpected: got byte 0x%0h, want no pulse", tx_data);
            end else begin
               chk("tx_data", int'(tx_data), int'(txq.pop_front()));
            end
            if (tmo_chk && last_start >= 0) chk("tmo_spacing", cyc - last_start, TMO + 3);
            last_start = cyc;
         end
      end
   end

   // one call per clock cycle; the model reflects what the next edge commits
   task automatic step(input bit s, input logic [7:0] rb, input bit rd, input bit clr,
                       input bit w, input logic [7:0] wb, input bit wexp);
      bit pop, acc;
      @(posedge clk); #1;
      ovr_now = ovr_next;
      cur_n   = rx_n;
      rx_strobe = s; rx_data = rb; rd_en = rd; clr_overrun = clr; wr_en = w; wr_data = wb;
      pop = rd && rx_n > 0;
      acc = s && (rx_n < D || pop);
      if (acc) rxq.push_back(rb);
      rx_n = rx_n + int'(acc) - int'(pop);
      ovr_next = clr ? 1'b0 : ((s && !acc) ? 1'b1 : ovr_now);
      if (w && wexp) txq.push_back(wb);
      if (rx_n >= HI && !xoff_exp) begin
         txq.push_front(8'h13);
         xoff_exp = 1;
      end else if (rx_n <= LO && xoff_exp) begin
         txq.push_front(8'h11);
         xoff_exp = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 8'h00, 0);
   endtask
   task automatic rx(input logic [7:0] b);  step(1, b, 0, 0, 0, 8'h00, 0); endtask
   task automatic pop1();                   step(0, 8'h00, 1, 0, 0, 8'h00, 0); endtask
   task automatic wr(input logic [7:0] b);  step(0, 8'h00, 0, 0, 1, b, 1); endtask

   task automatic drain();
      int k;
      k = 0;
      while ((txq.size() != 0 || bcnt != 0) && k < 600) begin
         idle(1);
         k++;
      end
      chk("drain_pending", txq.size(), 0);
      idle(8);
   endtask

   task automatic wait_start();
      int s0, k;
      s0 = starts;
      k  = 0;
      while (starts == s0 && k < 100) begin
         idle(1);
         k++;
      end
      chk("start_seen", int'(starts != s0), 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_tx_start", int'(tx_start), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_rx_count", int'(rx_count), 0);
      chk("rst_wr_full", int'(wr_full), 0);
      chk("rst_overrun", int'(overrun), 0);
   endtask

   initial begin
      int s0;
      bit s, r, c, w;
      #2 rst_n = 1'b0;
      #1 check_reset_outputs();
      @(posedge clk); #1 rst_n = 1'b1;
      idle(20);

      // two back-to-back writes with a slow transmitter
      busy_en = 1; busy_len = 10;
      s0 = starts;
      wr(8'h41); wr(8'h42);
      drain();
      chk("hs_start_count", starts - s0, 2);

      // overrun: the ninth byte is dropped and flagged
      for (int i = 0; i < 8; i++) rx(8'(i));
      rx(8'h55);
      idle(4);
      for (int i = 0; i < 8; i++) pop1();
      step(0, 8'h00, 0, 1, 0, 8'h00, 0);
      idle(2);
      drain();

      // full with simultaneous push and pop
      for (int i = 0; i < 8; i++) rx(8'hA0 + 8'(i));
      idle(4);
      step(1, 8'hB0, 1, 0, 0, 8'h00, 0);
      idle(1);
      for (int i = 0; i < 8; i++) pop1();
      drain();

      // XOFF pre-empts queued data once the byte in flight finishes; XON once on drain
      wr(8'h41);
      wait_start();
      wr(8'h42);
      for (int i = 0; i < 6; i++) rx(8'hC0 + 8'(i));
      drain();
      for (int i = 0; i < 4; i++) pop1();
      drain();
      pop1(); pop1();
      drain();

      // TX full: the extra write is dropped silently
      busy_len = 40;
      wr(8'h30);
      wait_start();
      for (int i = 0; i < 8; i++) wr(8'h60 + 8'(i));
      idle(1);
      @(negedge clk); #1;
      chk("wr_full", int'(wr_full), 1);
      step(0, 8'h00, 0, 0, 1, 8'hEE, 0);
      drain();

      // busy never rises: each byte is released by the timeout
      busy_en = 0; busy_len = 10;
      tmo_chk = 1; last_start = -1;
      wr(8'h71); wr(8'h72); wr(8'h73);
      drain();
      tmo_chk = 0;

      // random traffic kept below the XOFF watermark
      for (int b = 0; b < 6; b++) begin
         busy_en  = $urandom_range(0, 1);
         busy_len = $urandom_range(1, 6);
         for (int i = 0; i < 50; i++) begin
            s = ($urandom % 3 == 0) && rx_n < HI - 1;
            r = ($urandom % 3 == 0);
            c = ($urandom % 16 == 0);
            w = ($urandom % 3 == 0) && txq.size() < 7;
            step(s, 8'($urandom), r, c, w, 8'($urandom), w);
         end
         drain();
      end
      while (rx_n > 0) pop1();
      idle(2);

      // reset in the middle of a transfer abandons everything
      busy_en = 1; busy_len = 10;
      wr(8'h51); wr(8'h52); rx(8'h9A);
      wait_start();
      idle(3);
      @(posedge clk); #3 rst_n = 1'b0;
      #1 check_reset_outputs();
      rxq.delete(); txq.delete();
      rx_n = 0; cur_n = 0; ovr_now = 0; ovr_next = 0; xoff_exp = 0;
      rx_strobe = 0; rd_en = 0; wr_en = 0; clr_overrun = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      idle(20);
      wr(8'h5A);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
